// File: rtl/rv_pkg.sv
// Types and constants shared by the fetch unit and the decoder stage.
package rv_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2,
        HOLD = 2'd3
    } ifu_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory, decoder handshake and redirect signals of the fetch unit.
interface instr_fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_valid;
    logic [31:0]     imem_rdata;
    logic            instr_valid;
    logic            dec_ready;
    logic [31:0]     instr_out;
    logic [XLEN-1:0] pc_out;
    logic            redirect;
    logic [XLEN-1:0] redirect_target;
    logic [31:0]     fetch_count;

    modport master (
        output imem_req, imem_addr, instr_valid, instr_out, pc_out, fetch_count,
        input  imem_valid, imem_rdata, dec_ready, redirect, redirect_target
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr_out, pc_out, fetch_count,
        output imem_valid, imem_rdata, dec_ready, redirect, redirect_target
    );
endinterface

// File: rtl/ifu_pc_reg.sv
// Program counter: redirect load (word aligned), +4 increment, or hold.
module ifu_pc_reg #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [XLEN-1:0] target,
    input  logic            inc,
    output logic [XLEN-1:0] pc_q,
    output logic [XLEN-1:0] pc_d
);

    // pc_d is exported so a request issued this cycle can use the new PC.
    always_comb begin
        pc_d = pc_q;
        if (load)
            pc_d = target & ~XLEN'(3);
        else if (inc)
            pc_d = pc_q + XLEN'(4);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc_q <= RESET_PC;
        else        pc_q <= pc_d;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch unit: single-outstanding imem requests, valid/ready to decoder,
// redirects discard wrong-path responses.
module instr_fetch_unit
    import rv_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic                clk,
    input  logic                rst_n,
    instr_fetch_unit_if.master  io
);

    ifu_state_t      state_q, state_d;
    logic            req_q, req_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic            vld_q, vld_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] pcout_q, pcout_d;
    logic [31:0]     cnt_q, cnt_d;
    logic            pc_load, pc_inc;
    logic [XLEN-1:0] pc_q, pc_d;

    ifu_pc_reg #(.XLEN(XLEN), .RESET_PC(RESET_PC)) u_pc (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (pc_load),
        .target (io.redirect_target),
        .inc    (pc_inc),
        .pc_q   (pc_q),
        .pc_d   (pc_d)
    );

    always_comb begin
        state_d = state_q;
        req_d   = 1'b0;
        vld_d   = vld_q;
        instr_d = instr_q;
        pcout_d = pcout_q;
        cnt_d   = cnt_q;
        pc_load = 1'b0;
        pc_inc  = 1'b0;
        case (state_q)
            IDLE: begin
                req_d   = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                if (io.redirect) begin
                    pc_load = 1'b1;
                    if (io.imem_valid) req_d   = 1'b1;
                    else               state_d = DROP;
                end else if (io.imem_valid) begin
                    instr_d = io.imem_rdata;
                    pcout_d = pc_q;
                    vld_d   = 1'b1;
                    pc_inc  = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // A redirect flushes the held word, even if the decoder is ready.
                if (io.redirect) begin
                    vld_d   = 1'b0;
                    pc_load = 1'b1;
                    req_d   = 1'b1;
                    state_d = WAIT;
                end else if (io.dec_ready) begin
                    cnt_d   = cnt_q + 32'd1;
                    vld_d   = 1'b0;
                    req_d   = 1'b1;
                    state_d = WAIT;
                end
            end
            DROP: begin
                pc_load = io.redirect;
                if (io.imem_valid) begin
                    req_d   = 1'b1;
                    state_d = WAIT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign addr_d = req_d ? pc_d : addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
            vld_q   <= 1'b0;
            instr_q <= NOP_INSTR;
            pcout_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            vld_q   <= vld_d;
            instr_q <= instr_d;
            pcout_q <= pcout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign io.imem_req    = req_q;
    assign io.imem_addr   = addr_q;
    assign io.instr_valid = vld_q;
    assign io.instr_out   = instr_q;
    assign io.pc_out      = pcout_q;
    assign io.fetch_count = cnt_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed and randomized bench for instr_fetch_unit with a transaction-level model.
module tb_instr_fetch_unit;
    import rv_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_fetch_unit_if #(.XLEN(32)) bus ();
    instr_fetch_unit_if #(.XLEN(32)) wbus ();

    instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) u_dut (
        .clk(clk), .rst_n(rst_n), .io(bus)
    );
    instr_fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst_n(rst_n), .io(wbus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic timeout(input string tag);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out", tag);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0010_0093;
        if (a == 32'h4) return 32'h0020_0113;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    // ---------------- memory responder (acts at posedge+2) ----------------
    int          lat_cfg = 1;   // 0 = random latency 1..4
    bit          force_valid = 1'b0;
    bit          pend = 1'b0;
    int          pcnt = 0;
    logic [31:0] paddr = '0;

    initial begin
        bus.imem_valid = 1'b0;
        bus.imem_rdata = '0;
        forever begin
            @(posedge clk); #2;
            bus.imem_valid = 1'b0;
            if (!rst_n) pend = 1'b0;
            if (force_valid) begin
                bus.imem_valid = 1'b1;
                bus.imem_rdata = 32'hDEAD_BEEF;
            end else if (pend) begin
                if (pcnt <= 1) begin
                    bus.imem_valid = 1'b1;
                    bus.imem_rdata = mem_word(paddr);
                    pend = 1'b0;
                end else pcnt--;
            end
            if (rst_n && bus.imem_req) begin
                pend  = 1'b1;
                paddr = bus.imem_addr;
                pcnt  = (lat_cfg == 0) ? int'($urandom_range(4, 1)) : lat_cfg;
            end
        end
    end

    // Wrap-around instance: latency-1 memory, decoder always ready.
    bit          wpend = 1'b0;
    logic [31:0] wpaddr = '0;
    logic [31:0] wq[$];
    initial begin
        wbus.imem_valid = 1'b0;
        wbus.imem_rdata = '0;
        wbus.dec_ready = 1'b1;
        wbus.redirect = 1'b0;
        wbus.redirect_target = '0;
        forever begin
            @(posedge clk); #2;
            wbus.imem_valid = wpend;
            wbus.imem_rdata = mem_word(wpaddr);
            wpend  = rst_n && wbus.imem_req;
            wpaddr = wbus.imem_addr;
        end
    end
    initial forever begin
        @(negedge clk);
        if (rst_n && wbus.instr_valid && wbus.dec_ready) wq.push_back(wbus.pc_out);
    end

    // ---------------- reference model (evaluated at negedge) ----------------
    // Next fetch address follows: redirect -> aligned target; accepted word p -> p+4.
    logic [31:0] m_fetch = '0;
    int unsigned m_cnt = 0;
    bit          m_out = 1'b0, m_clean = 1'b0, m_started = 1'b0;
    logic [31:0] req_log[$];
    logic [31:0] hs_instr[$];
    logic [31:0] hs_pc[$];

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            m_fetch = '0; m_cnt = 0; m_out = 1'b0; m_clean = 1'b0; m_started = 1'b0;
        end else begin
            chk("fetch_count", bus.fetch_count, m_cnt);
            if (bus.imem_req) begin
                chk("req_addr", bus.imem_addr, m_fetch);
                chk("one_outstanding", 32'(m_out), 32'd0);
                chk("req_while_valid", 32'(bus.instr_valid), 32'd0);
                m_out = 1'b1; m_clean = 1'b1; m_started = 1'b1;
                req_log.push_back(bus.imem_addr);
            end
            if (bus.imem_valid) m_out = 1'b0;
            if (bus.instr_valid) begin
                chk("pc_out", bus.pc_out, m_fetch);
                chk("instr_out", bus.instr_out, mem_word(bus.pc_out));
                chk("wrong_path", 32'(m_clean), 32'd1);
            end
            if (bus.redirect && m_started) begin
                m_fetch = bus.redirect_target & ~32'd3;
                m_clean = 1'b0;
            end else if (bus.instr_valid && bus.dec_ready) begin
                m_cnt++;
                m_fetch = m_fetch + 32'd4;
                hs_instr.push_back(bus.instr_out);
                hs_pc.push_back(bus.pc_out);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic wait_req(input string tag, output logic [31:0] a);
        a = 'x;
        for (int i = 0; i < 60; i++) begin
            cyc();
            if (bus.imem_req) begin a = bus.imem_addr; return; end
        end
        timeout(tag);
    endtask

    task automatic wait_vld(input string tag);
        for (int i = 0; i < 60; i++) begin
            cyc();
            if (bus.instr_valid) return;
        end
        timeout(tag);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req"},   32'(bus.imem_req), 32'd0);
        chk({tag, "_vld"},   32'(bus.instr_valid), 32'd0);
        chk({tag, "_instr"}, bus.instr_out, NOP_INSTR);
        chk({tag, "_pc"},    bus.pc_out, 32'h0);
        chk({tag, "_cnt"},   bus.fetch_count, 32'h0);
    endtask

    logic [31:0] a, h_i, h_p, fc;
    bit saw;

    initial begin
        bus.dec_ready = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_target = '0;
        repeat (3) cyc();
        @(negedge clk);
        chk_reset_vals("rst");

        // basic stream, latency 1, decoder always ready
        @(posedge clk); #1;
        lat_cfg = 1;
        bus.dec_ready = 1'b1;
        rst_n = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 40 && !saw; i++) begin
            cyc();
            if (bus.fetch_count == 32'd2) saw = 1'b1;
        end
        bus.dec_ready = 1'b0;
        if (!saw || req_log.size() < 2 || hs_pc.size() < 2) timeout("basic_stream");
        else begin
            chk("basic_addr0", req_log[0], 32'h0);
            chk("basic_addr1", req_log[1], 32'h4);
            chk("basic_i0", hs_instr[0], 32'h0010_0093);
            chk("basic_p0", hs_pc[0], 32'h0);
            chk("basic_i1", hs_instr[1], 32'h0020_0113);
            chk("basic_p1", hs_pc[1], 32'h4);
        end

        // back-pressure
        wait_vld("bp_vld");
        h_i = bus.instr_out;
        h_p = bus.pc_out;
        repeat (5) begin
            @(negedge clk);
            chk("bp_vld", 32'(bus.instr_valid), 32'd1);
            chk("bp_instr", bus.instr_out, h_i);
            chk("bp_pc", bus.pc_out, h_p);
            chk("bp_noreq", 32'(bus.imem_req), 32'd0);
        end
        @(posedge clk); #1;
        bus.dec_ready = 1'b1;
        wait_req("bp_req", a);
        chk("bp_next_addr", a, h_p + 32'd4);

        // redirect in WAIT, stale response 3 cycles later
        lat_cfg = 3;
        bus.dec_ready = 1'b0;
        bus.redirect = 1'b1;
        bus.redirect_target = 32'h0000_0102;
        cyc();
        bus.redirect = 1'b0;
        saw = 1'b0;
        a = 'x;
        for (int i = 0; i < 20; i++) begin
            if (bus.instr_valid) saw = 1'b1;
            if (bus.imem_req) begin a = bus.imem_addr; break; end
            cyc();
        end
        chk("drop_addr", a, 32'h100);
        chk("drop_novld", 32'(saw), 32'd0);
        wait_vld("drop_vld");
        chk("drop_pc", bus.pc_out, 32'h100);

        // redirect coincident with response
        lat_cfg = 2;
        bus.dec_ready = 1'b1;
        wait_req("rv_req", a);
        bus.dec_ready = 1'b0;
        cyc();
        cyc();
        bus.redirect = 1'b1;
        bus.redirect_target = 32'h40;
        @(negedge clk);
        chk("rv_same_cycle", 32'(bus.imem_valid), 32'd1);
        @(posedge clk); #1;
        bus.redirect = 1'b0;
        chk("rv_req", 32'(bus.imem_req), 32'd1);
        chk("rv_addr", bus.imem_addr, 32'h40);
        chk("rv_novld", 32'(bus.instr_valid), 32'd0);

        // redirect in HOLD with decoder ready
        lat_cfg = 1;
        wait_vld("hold_vld");
        fc = bus.fetch_count;
        bus.dec_ready = 1'b1;
        bus.redirect = 1'b1;
        bus.redirect_target = 32'h80;
        cyc();
        bus.redirect = 1'b0;
        bus.dec_ready = 1'b0;
        chk("flush_vld", 32'(bus.instr_valid), 32'd0);
        chk("flush_cnt", bus.fetch_count, fc);
        chk("flush_req", 32'(bus.imem_req), 32'd1);
        chk("flush_addr", bus.imem_addr, 32'h80);

        // randomized traffic
        lat_cfg = 0;
        for (int i = 0; i < 3000; i++) begin
            cyc();
            bus.dec_ready = ($urandom_range(99) < 70);
            bus.redirect = ($urandom_range(99) < 6);
            bus.redirect_target = $urandom;
        end
        bus.redirect = 1'b0;
        bus.dec_ready = 1'b1;

        // reset while a request is outstanding, stray response afterwards
        lat_cfg = 3;
        wait_req("rst_req", a);
        cyc();
        rst_n = 1'b0;
        force_valid = 1'b1;
        @(negedge clk);
        chk_reset_vals("rst_wait");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("stray_valid", 32'(bus.imem_valid), 32'd1);
        @(posedge clk); #1;
        force_valid = 1'b0;
        lat_cfg = 1;
        wait_vld("rst_vld");
        chk("rst_instr", bus.instr_out, 32'h0010_0093);
        chk("rst_pc", bus.pc_out, 32'h0);

        // wrap-around instance
        if (wq.size() < 2) timeout("wrap");
        else begin
            chk("wrap_p0", wq[0], 32'hFFFF_FFFC);
            chk("wrap_p1", wq[1], 32'h0);
        end

        repeat (2) cyc();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
